axil_reg_if_rd: RTL and testbench
=================================

AXIL_REG_IF_RD -- requirements
Module: axil_reg_if_rd

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of the data bus in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32: width of the address bus in bits.
REQ-003 The block SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8: data bus width in bytes.
REQ-004 The block SHALL have parameter TIMEOUT, default 16: register-access timeout in cycles; 0 disables the timeout.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous active-high reset
- s_axil_araddr  input  ADDR_WIDTH  read address
- s_axil_arprot  input  3  protection; accepted and ignored
- s_axil_arvalid  input  1  AR valid
- s_axil_arready  output  1  AR ready
- s_axil_rdata  output  DATA_WIDTH  read data
- s_axil_rresp  output  2  read response
- s_axil_rvalid  output  1  R valid
- s_axil_rready  input  1  R ready
- reg_rd_addr  output  ADDR_WIDTH  register address, word-aligned
- reg_rd_en  output  1  register read request, held until completion
- reg_rd_data  input  DATA_WIDTH  register read data, valid with ack
- reg_rd_wait  input  1  register busy; extends the timeout
- reg_rd_ack  input  1  register read complete

Function
REQ-006 The block SHALL implement three states: IDLE, WAIT and RESP, with at most one read outstanding.
REQ-007 In IDLE, s_axil_arready SHALL be 1 (registered); in WAIT and RESP it SHALL be 0.
REQ-008 An AR handshake (arvalid & arready) in cycle N SHALL move the block to WAIT, with reg_rd_en=1 from cycle N+1.
REQ-009 On that handshake, reg_rd_addr SHALL load s_axil_araddr with its low $clog2(STRB_WIDTH) bits forced to 0; it SHALL hold that value until the next AR handshake.
REQ-010 In WAIT, reg_rd_en SHALL stay 1 until the cycle in which reg_rd_ack=1 or the timeout fires; reg_rd_en SHALL drop the following cycle.
REQ-011 reg_rd_ack=1 in WAIT SHALL capture reg_rd_data into s_axil_rdata, set s_axil_rresp=2'b00 (OKAY), and enter RESP with s_axil_rvalid=1 in the next cycle.
- Minimum AR-handshake-to-rvalid latency is 2 cycles (ack at N+1, rvalid at N+2).
REQ-012 The timeout counter SHALL be $clog2(TIMEOUT+1) bits and SHALL clear on entry to WAIT and in every cycle with reg_rd_wait=1.
- Otherwise it increments once per WAIT cycle.
- The timeout fires in the WAIT cycle where the counter equals TIMEOUT-1 and reg_rd_wait=0.
REQ-013 On timeout, the block SHALL set s_axil_rdata=0 and s_axil_rresp=2'b10 (SLVERR), and enter RESP.
REQ-014 If reg_rd_ack=1 in the same cycle the timeout would fire, ack SHALL win (OKAY with data).
REQ-015 With TIMEOUT=0 the block SHALL wait indefinitely for reg_rd_ack.
REQ-016 reg_rd_ack or reg_rd_wait asserted outside WAIT SHALL be ignored.
REQ-017 In RESP, s_axil_rvalid, rdata and rresp SHALL hold stable until s_axil_rready=1.
- The R handshake in cycle M SHALL return the block to IDLE, with rvalid=0 and arready=1 at M+1.
REQ-018 s_axil_arvalid SHALL have no effect while arready=0; no address is buffered.

Reset
REQ-019 While rst=1 the block SHALL drive s_axil_arready=0, s_axil_rvalid=0, s_axil_rdata=0, s_axil_rresp=0, reg_rd_en=0 and reg_rd_addr=0, and SHALL enter IDLE with the counter cleared.
REQ-020 s_axil_arready SHALL rise in the first cycle after rst is deasserted.
REQ-021 A reset in WAIT or RESP SHALL abandon the transaction and produce no R beat afterwards.

Verification
REQ-022 Basic read: araddr=0x0000_0013, reg_rd_ack=1 one cycle after reg_rd_en rises, reg_rd_data=0xDEADBEEF, rready=1 -> reg_rd_addr=0x10, rdata=0xDEADBEEF, rresp=00, rvalid 2 cycles after the AR handshake.
REQ-023 Timeout: TIMEOUT=16, no ack, reg_rd_wait=0 -> reg_rd_en high for exactly 16 cycles, then rresp=10 and rdata=0.
REQ-024 Wait extension: TIMEOUT=4, reg_rd_wait=1 for 10 cycles, then ack 2 cycles later -> OKAY response, no SLVERR.
REQ-025 Tie: TIMEOUT=4, ack in the 4th WAIT cycle -> rresp=00 with the captured data.
REQ-026 Backpressure: rready=0 for 5 cycles, arvalid held high with a second address -> R beat stable and arready=0 throughout; second AR accepted 1 cycle after the R handshake.
REQ-027 Reset mid-WAIT: rst=1 for 1 cycle during WAIT, then ack -> no rvalid, reg_rd_en=0, arready=1 the cycle after reset release.

Source files
------------

// File: rtl/axil_reg_if_rd.sv
// AXI4-Lite read slave that bridges single reads onto a simple register
// read port (enable / data / wait / ack). Only one read is in flight at a
// time. A read that the register side neither acknowledges nor extends
// with reg_rd_wait returns SLVERR after TIMEOUT cycles.
module axil_reg_if_rd #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,

  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack
);

  // Byte-offset bits below the word boundary are cleared on the register side.
  localparam int ADDR_LSB = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << ADDR_LSB) - ADDR_WIDTH'(1));

  // The counter needs $clog2(TIMEOUT+1) bits; keep at least one bit so the
  // TIMEOUT=0 (never time out) build still elaborates.
  localparam int CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] to_cnt;
  logic             timeout_fire;

  // Protection bits carry no meaning for a register read.
  logic unused_arprot;
  assign unused_arprot = ^s_axil_arprot;

  // Timeout fires on the last counted WAIT cycle unless the register side is
  // holding the access open with reg_rd_wait.
  assign timeout_fire = (TIMEOUT != 0) && !reg_rd_wait && (to_cnt == TO_LAST);

  // Transaction FSM with all interface outputs registered.
  // NOTE: every assignment here is non-blocking so all state and outputs
  // update together from the values seen at the same clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= '0;
      s_axil_rresp   <= RESP_OKAY;
      reg_rd_en      <= 1'b0;
      reg_rd_addr    <= '0;
      to_cnt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          s_axil_arready <= 1'b1;
          if (s_axil_arvalid && s_axil_arready) begin
            s_axil_arready <= 1'b0;
            reg_rd_addr    <= s_axil_araddr & ADDR_MASK;
            reg_rd_en      <= 1'b1;
            to_cnt         <= '0;
            state          <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (reg_rd_ack) begin
            // Ack takes priority over a timeout firing in the same cycle.
            reg_rd_en     <= 1'b0;
            s_axil_rdata  <= reg_rd_data;
            s_axil_rresp  <= RESP_OKAY;
            s_axil_rvalid <= 1'b1;
            state         <= S_RESP;
          end else if (timeout_fire) begin
            reg_rd_en     <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_SLVERR;
            s_axil_rvalid <= 1'b1;
            state         <= S_RESP;
          end else if (reg_rd_wait) begin
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end

        S_RESP: begin
          // R beat holds until accepted; no new address is taken meanwhile.
          if (s_axil_rready) begin
            s_axil_rvalid  <= 1'b0;
            s_axil_arready <= 1'b1;
            state          <= S_IDLE;
          end
        end

        default: begin
          state          <= S_IDLE;
          s_axil_arready <= 1'b0;
          s_axil_rvalid  <= 1'b0;
          reg_rd_en      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_if_rd.sv
// Directed bench for axil_reg_if_rd. Three instances share one stimulus:
// TIMEOUT=16, TIMEOUT=4 and TIMEOUT=0. A cycle table covers reset, a basic
// read, ignored acks and reset during WAIT; hand sequences cover timeout,
// wait extension, ack/timeout tie and R backpressure.
module tb_axil_reg_if_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        rready;
  logic [31:0] rd_data;
  logic        rd_wait;
  logic        rd_ack;

  typedef struct packed {
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic [31:0] addr;
    logic        en;
  } outs_t;

  outs_t o16, o4, o0;

  axil_reg_if_rd #(.TIMEOUT(16)) dut16 (
    .clk(clk), .rst(rst),
    .s_axil_araddr(araddr), .s_axil_arprot(3'b000), .s_axil_arvalid(arvalid),
    .s_axil_arready(o16.arready), .s_axil_rdata(o16.rdata), .s_axil_rresp(o16.rresp),
    .s_axil_rvalid(o16.rvalid), .s_axil_rready(rready),
    .reg_rd_addr(o16.addr), .reg_rd_en(o16.en), .reg_rd_data(rd_data),
    .reg_rd_wait(rd_wait), .reg_rd_ack(rd_ack)
  );

  axil_reg_if_rd #(.TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst),
    .s_axil_araddr(araddr), .s_axil_arprot(3'b010), .s_axil_arvalid(arvalid),
    .s_axil_arready(o4.arready), .s_axil_rdata(o4.rdata), .s_axil_rresp(o4.rresp),
    .s_axil_rvalid(o4.rvalid), .s_axil_rready(rready),
    .reg_rd_addr(o4.addr), .reg_rd_en(o4.en), .reg_rd_data(rd_data),
    .reg_rd_wait(rd_wait), .reg_rd_ack(rd_ack)
  );

  axil_reg_if_rd #(.TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst),
    .s_axil_araddr(araddr), .s_axil_arprot(3'b111), .s_axil_arvalid(arvalid),
    .s_axil_arready(o0.arready), .s_axil_rdata(o0.rdata), .s_axil_rresp(o0.rresp),
    .s_axil_rvalid(o0.rvalid), .s_axil_rready(rready),
    .reg_rd_addr(o0.addr), .reg_rd_en(o0.en), .reg_rd_data(rd_data),
    .reg_rd_wait(rd_wait), .reg_rd_ack(rd_ack)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock: inputs set beforehand, outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arvalid = 1'b0;
    araddr  = '0;
    rready  = 1'b0;
    rd_data = '0;
    rd_wait = 1'b0;
    rd_ack  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic ar(input logic [31:0] a);
    arvalid = 1'b1;
    araddr  = a;
    step();
    arvalid = 1'b0;
  endtask

  // Per-cycle vector: inputs for the cycle, expected outputs after its edge.
  typedef struct {
    logic        rst;
    logic        arvalid;
    logic [31:0] araddr;
    logic        ack;
    logic        wt;
    logic [31:0] data;
    logic        rready;
    logic        exp_arready;
    logic        exp_rvalid;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        chk_r;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  initial begin
    int    c16;
    int    c4;
    logic  ok;
    rst = 1'b1;
    idle_inputs();

    //           rst av araddr        ack wt data          rr  ard rv en addr          chk rdata         rresp
    vecs[0]  = '{1, 0, 32'h0,         0,  0, 32'h0,        0,  0,  0, 0, 32'h0,        1,  32'h0,        2'b00};
    vecs[1]  = '{0, 0, 32'h0,         0,  0, 32'h0,        0,  1,  0, 0, 32'h0,        0,  32'h0,        2'b00};
    vecs[2]  = '{0, 1, 32'h0000_0013, 0,  0, 32'h0,        1,  0,  0, 1, 32'h10,       0,  32'h0,        2'b00};
    vecs[3]  = '{0, 0, 32'h0,         1,  0, 32'hDEADBEEF, 0,  0,  1, 0, 32'h10,       1,  32'hDEADBEEF, 2'b00};
    vecs[4]  = '{0, 0, 32'h0,         0,  0, 32'h0,        1,  1,  0, 0, 32'h10,       0,  32'h0,        2'b00};
    vecs[5]  = '{0, 0, 32'h0,         1,  1, 32'h1234_5678,0,  1,  0, 0, 32'h10,       0,  32'h0,        2'b00};
    vecs[6]  = '{0, 1, 32'hFFFF_FFFF, 0,  0, 32'h0,        0,  0,  0, 1, 32'hFFFF_FFFC,0,  32'h0,        2'b00};
    vecs[7]  = '{0, 0, 32'h0,         0,  1, 32'h0,        0,  0,  0, 1, 32'hFFFF_FFFC,0,  32'h0,        2'b00};
    vecs[8]  = '{1, 0, 32'h0,         0,  0, 32'h0,        0,  0,  0, 0, 32'h0,        1,  32'h0,        2'b00};
    vecs[9]  = '{0, 0, 32'h0,         1,  0, 32'hCAFE_F00D,1,  1,  0, 0, 32'h0,        0,  32'h0,        2'b00};
    vecs[10] = '{0, 0, 32'h0,         1,  0, 32'hCAFE_F00D,1,  1,  0, 0, 32'h0,        0,  32'h0,        2'b00};

    for (int i = 0; i < NVEC; i++) begin
      rst     = vecs[i].rst;
      arvalid = vecs[i].arvalid;
      araddr  = vecs[i].araddr;
      rd_ack  = vecs[i].ack;
      rd_wait = vecs[i].wt;
      rd_data = vecs[i].data;
      rready  = vecs[i].rready;
      step();
      check($sformatf("vec%0d.arready", i), 64'(o16.arready), 64'(vecs[i].exp_arready));
      check($sformatf("vec%0d.rvalid", i),  64'(o16.rvalid),  64'(vecs[i].exp_rvalid));
      check($sformatf("vec%0d.en", i),      64'(o16.en),      64'(vecs[i].exp_en));
      check($sformatf("vec%0d.addr", i),    64'(o16.addr),    64'(vecs[i].exp_addr));
      if (vecs[i].chk_r) begin
        check($sformatf("vec%0d.rdata", i), 64'(o16.rdata), 64'(vecs[i].exp_rdata));
        check($sformatf("vec%0d.rresp", i), 64'(o16.rresp), 64'(vecs[i].exp_rresp));
      end
    end

    // Timeout: no ack, no wait. TIMEOUT=16 holds en for 16 cycles,
    // TIMEOUT=4 for 4, TIMEOUT=0 never gives up.
    do_reset();
    ar(32'h0000_0040);
    c16 = 0;
    c4  = 0;
    for (int i = 0; i < 20; i++) begin
      if (o16.en) c16++;
      if (o4.en)  c4++;
      step();
    end
    check("to16.en_cycles", 64'(c16), 64'd16);
    check("to16.rvalid",    64'(o16.rvalid), 64'd1);
    check("to16.rresp",     64'(o16.rresp),  64'd2);
    check("to16.rdata",     64'(o16.rdata),  64'd0);
    check("to4.en_cycles",  64'(c4), 64'd4);
    check("to4.rresp",      64'(o4.rresp),   64'd2);
    check("to0.en_held",    64'(o0.en),      64'd1);
    check("to0.no_rvalid",  64'(o0.rvalid),  64'd0);
    rd_ack  = 1'b1;
    rd_data = 32'h0BAD_0000;
    step();
    rd_ack = 1'b0;
    check("to0.ack_rvalid", 64'(o0.rvalid), 64'd1);
    check("to0.ack_rresp",  64'(o0.rresp),  64'd0);
    check("to0.ack_rdata",  64'(o0.rdata),  64'h0BAD_0000);
    rready = 1'b1;
    step();
    rready = 1'b0;
    check("to16.r_done", 64'(o16.rvalid),  64'd0);
    check("to16.arready", 64'(o16.arready), 64'd1);

    // Wait extension on TIMEOUT=4: wait held 10 cycles, then ack 2 cycles later.
    do_reset();
    ar(32'h0000_0080);
    rd_wait = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!o4.en || o4.rvalid) ok = 1'b0;
    end
    check("wext.en_held", 64'(ok), 64'd1);
    rd_wait = 1'b0;
    step();
    check("wext.gap_en", 64'(o4.en), 64'd1);
    rd_ack  = 1'b1;
    rd_data = 32'h5555_AAAA;
    step();
    rd_ack = 1'b0;
    check("wext.rvalid", 64'(o4.rvalid), 64'd1);
    check("wext.rresp",  64'(o4.rresp),  64'd0);
    check("wext.rdata",  64'(o4.rdata),  64'h5555_AAAA);

    // Tie on TIMEOUT=4: ack lands in the 4th WAIT cycle, when the timeout would fire.
    do_reset();
    ar(32'h0000_00C0);
    step();
    step();
    step();
    check("tie.en_before", 64'(o4.en), 64'd1);
    rd_ack  = 1'b1;
    rd_data = 32'hA5A5_0004;
    step();
    rd_ack = 1'b0;
    check("tie.rvalid", 64'(o4.rvalid), 64'd1);
    check("tie.rresp",  64'(o4.rresp),  64'd0);
    check("tie.rdata",  64'(o4.rdata),  64'hA5A5_0004);

    // Backpressure: rready low 5 cycles with a second address pending.
    do_reset();
    ar(32'h0000_0100);
    rd_ack  = 1'b1;
    rd_data = 32'h1111_2222;
    step();
    rd_ack  = 1'b0;
    rd_data = 32'h9999_9999;
    arvalid = 1'b1;
    araddr  = 32'h0000_0206;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!o16.rvalid || o16.rdata !== 32'h1111_2222 || o16.rresp !== 2'b00 ||
          o16.arready || o16.en || o16.addr !== 32'h0000_0100) ok = 1'b0;
    end
    check("bp.stable", 64'(ok), 64'd1);
    rready = 1'b1;
    step();
    rready = 1'b0;
    check("bp.rvalid_drop", 64'(o16.rvalid),  64'd0);
    check("bp.arready_up",  64'(o16.arready), 64'd1);
    check("bp.en_idle",     64'(o16.en),      64'd0);
    step();
    arvalid = 1'b0;
    check("bp.ar2_taken",  64'(o16.arready), 64'd0);
    check("bp.ar2_en",     64'(o16.en),      64'd1);
    check("bp.ar2_addr",   64'(o16.addr),    64'h0000_0204);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
